// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - constants shared by the UART transmit path
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  localparam logic [1:0] ST_ARB  = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [UART_BYTE_W-1:0] DEFAULT_HEADER_BASE = 8'hA0;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or after ptr, cyclically
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] index,
  output logic [N_REQ-1:0] onehot
);

  logic             hi_v;
  logic [PTR_W-1:0] hi_idx;
  logic             lo_v;
  logic [PTR_W-1:0] lo_idx;

  // Lowest request at/above ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_v   = 1'b0;
    hi_idx = '0;
    lo_v   = 1'b0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_v   = 1'b1;
        lo_idx = PTR_W'(i);
        if (PTR_W'(i) >= ptr) begin
          hi_v   = 1'b1;
          hi_idx = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    valid  = lo_v;
    index  = hi_v ? hi_idx : lo_idx;
    onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      onehot[i] = lo_v && (index == PTR_W'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one uart_send
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int                     N_REQ       = 4,
  parameter int                     SEND_HEADER = 1,
  parameter logic [UART_BYTE_W-1:0] HEADER_BASE = DEFAULT_HEADER_BASE,
  parameter logic [15:0]            TIMEOUT     = 16'd50000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [UART_BYTE_W*N_REQ-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]             REQ_VALID,
  input  logic [N_REQ-1:0]             REQ_LAST,
  output logic [N_REQ-1:0]             REQ_ACK,
  output logic [N_REQ-1:0]             GRANT,
  output logic                         BUSY,
  output logic [UART_BYTE_W-1:0]       TX_DATA,
  output logic                         TX_DATA_READY,
  input  logic                         TX_IDLE
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]             state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [PTR_W-1:0]       g_q, g_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [15:0]            stall_q, stall_d;
  logic [UART_BYTE_W-1:0] hdr_q, hdr_d;

  logic                   pick_valid;
  logic [PTR_W-1:0]       pick_index;
  logic [N_REQ-1:0]       pick_onehot;

  logic [UART_BYTE_W-1:0] g_data;
  logic                   g_valid;
  logic                   g_last;
  logic                   xfer;
  logic [PTR_W-1:0]       next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (REQ_VALID),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .index  (pick_index),
    .onehot (pick_onehot)
  );

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        g_data  = REQ_DATA[UART_BYTE_W*i +: UART_BYTE_W];
        g_valid = REQ_VALID[i];
        g_last  = REQ_LAST[i];
      end
    end
  end

  // Data phase is a straight combinational pass-through of the granted slice.
  always_comb begin
    TX_DATA       = '0;
    TX_DATA_READY = 1'b0;
    case (state_q)
      ST_HDR: begin
        TX_DATA       = hdr_q;
        TX_DATA_READY = 1'b1;
      end
      ST_DATA: begin
        TX_DATA       = g_data;
        TX_DATA_READY = g_valid;
      end
      default: begin
        TX_DATA       = '0;
        TX_DATA_READY = 1'b0;
      end
    endcase
  end

  assign xfer     = TX_DATA_READY && TX_IDLE;
  assign next_ptr = (g_q == PTR_W'(N_REQ - 1)) ? '0 : g_q + PTR_W'(1);
  assign GRANT    = grant_q;
  assign BUSY     = (state_q != ST_ARB);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    hdr_d   = hdr_q;
    REQ_ACK = '0;
    case (state_q)
      ST_ARB: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          g_d     = pick_index;
          hdr_d   = HEADER_BASE + UART_BYTE_W'(pick_index);
          stall_d = '0;
          state_d = (SEND_HEADER != 0) ? ST_HDR : ST_DATA;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          stall_d = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          REQ_ACK = grant_q;
          stall_d = '0;
          if (g_last) begin
            grant_d = '0;
            ptr_d   = next_ptr;
            state_d = ST_ARB;
          end
        end else if ((TIMEOUT != 16'd0) && (stall_q == TIMEOUT - 16'd1)) begin
          // Stalled owner is dropped like a LAST byte, but nothing is acknowledged.
          grant_d = '0;
          ptr_d   = next_ptr;
          stall_d = '0;
          state_d = ST_ARB;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_ARB;
      grant_q <= '0;
      g_q     <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      hdr_q   <= hdr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter (4-req header build and 1-req headerless build)
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a;
  logic        rst_n_b;
  logic [31:0] req_data_a;
  logic [3:0]  req_valid_a, req_last_a, req_ack_a, grant_a;
  logic        busy_a, tx_ready_a, tx_idle_a;
  logic [7:0]  tx_data_a;
  logic        hold_low = 1'b0;

  logic [7:0]  req_data_b;
  logic [0:0]  req_valid_b, req_last_b, req_ack_b, grant_b;
  logic        busy_b, tx_ready_b, tx_idle_b;
  logic [7:0]  tx_data_b;

  logic [8:0]  mem_a [4][64];
  int          wr_a [4];
  int          rd_a [4];
  int          ack_cnt [4];
  logic [8:0]  mem_b [64];
  int          wr_b = 0;
  int          rd_b = 0;

  logic [7:0]  tx_log [256];
  int          tx_n = 0;
  int          busy_cnt_a = 0;

  int          n_checks = 0;
  int          n_err = 0;

  uart_tx_arbiter #(
    .N_REQ(4), .SEND_HEADER(1), .HEADER_BASE(8'hA0), .TIMEOUT(16'd100)
  ) dut_a (
    .CLK(clk), .RST(rst_n_a), .REQ_DATA(req_data_a), .REQ_VALID(req_valid_a),
    .REQ_LAST(req_last_a), .REQ_ACK(req_ack_a), .GRANT(grant_a), .BUSY(busy_a),
    .TX_DATA(tx_data_a), .TX_DATA_READY(tx_ready_a), .TX_IDLE(tx_idle_a)
  );

  uart_tx_arbiter #(
    .N_REQ(1), .SEND_HEADER(0), .HEADER_BASE(8'hA0), .TIMEOUT(16'd100)
  ) dut_b (
    .CLK(clk), .RST(rst_n_b), .REQ_DATA(req_data_b), .REQ_VALID(req_valid_b),
    .REQ_LAST(req_last_b), .REQ_ACK(req_ack_b), .GRANT(grant_b), .BUSY(busy_b),
    .TX_DATA(tx_data_b), .TX_DATA_READY(tx_ready_b), .TX_IDLE(tx_idle_b)
  );

  assign tx_idle_a = (busy_cnt_a == 0) && !hold_low;
  assign tx_idle_b = 1'b1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_valid_a[i]          = (rd_a[i] != wr_a[i]);
      req_data_a[8*i +: 8]    = mem_a[i][rd_a[i]][7:0];
      req_last_a[i]           = mem_a[i][rd_a[i]][8];
    end
    req_valid_b[0] = (rd_b != wr_b);
    req_data_b     = mem_b[rd_b][7:0];
    req_last_b[0]  = mem_b[rd_b][8];
  end

  // Stand-in for uart_send: IDLE drops for 10 cycles after each accepted byte.
  always @(posedge clk) begin
    if (tx_ready_a && tx_idle_a) begin
      tx_log[tx_n] <= tx_data_a;
      tx_n         <= tx_n + 1;
      busy_cnt_a   <= 10;
    end else if (busy_cnt_a != 0) begin
      busy_cnt_a <= busy_cnt_a - 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (req_ack_a[i]) begin
        rd_a[i]    <= rd_a[i] + 1;
        ack_cnt[i] <= ack_cnt[i] + 1;
      end
    end
    if (req_ack_b[0]) rd_b <= rd_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem_a[r][wr_a[r]] = {l, d};
    wr_a[r] = wr_a[r] + 1;
  endtask

  task automatic push_b(input logic [7:0] d);
    mem_b[wr_b] = {1'b1, d};
    wr_b = wr_b + 1;
  endtask

  function automatic bit q_empty();
    for (int i = 0; i < 4; i++) if (wr_a[i] != rd_a[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] log_word(input int base, input int n);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w = {w[55:0], tx_log[base + k]};
    return w;
  endfunction

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while ((busy_a || !q_empty()) && c < 400) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, 64'(c < 400), 64'd1);
  endtask

  task automatic wait_ack(input string tag, input int r);
    int c;
    c = 0;
    while (!req_ack_a[r] && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_ack_seen"}, 64'(c < 200), 64'd1);
  endtask

  initial begin
    int base, a0, a1, a2, a3, c, bad;
    logic [7:0] ack_pat, busy_pat;
    logic [23:0] bytes_b;

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_outs", {grant_a, req_ack_a, busy_a, tx_ready_a, tx_data_a}, 64'd0);
    check("rst_b_outs", {grant_b, req_ack_b, busy_b, tx_ready_b, tx_data_b}, 64'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Single packet with header from requester 0
    @(posedge clk); #1;
    base = tx_n;
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    wait_ack("t1", 0);
    check("t1_grant", grant_a, 64'h1);
    wait_idle("t1");
    check("t1_acks", ack_cnt[0], 3);
    check("t1_nbytes", tx_n - base, 4);
    check("t1_bytes", log_word(base, 4), 64'hA0112233);
    check("t1_grant_after", grant_a, 0);

    // Simultaneous requests 1 and 2: whole packets, in order, no interleave
    @(posedge clk); #1;
    base = tx_n; a1 = ack_cnt[1]; a2 = ack_cnt[2];
    push(1, 8'h44, 1'b0); push(1, 8'h55, 1'b1); push(2, 8'h66, 1'b1);
    wait_idle("t2");
    check("t2_nbytes", tx_n - base, 5);
    check("t2_bytes", log_word(base, 5), 64'hA14455A266);
    check("t2_acks1", ack_cnt[1] - a1, 2);
    check("t2_acks2", ack_cnt[2] - a2, 1);

    // Requester 3 stalls after one byte; pointer 3 beats pending requester 0
    @(posedge clk); #1;
    base = tx_n; a0 = ack_cnt[0]; a3 = ack_cnt[3];
    push(3, 8'h77, 1'b0); push(0, 8'h88, 1'b1);
    wait_ack("t3", 3);
    c = 0;
    @(negedge clk);
    while (grant_a[3] && c < 300) begin
      c++;
      @(negedge clk);
    end
    check("t3_stall_cycles", c, 100);
    @(negedge clk);
    check("t3_next_grant", grant_a, 64'h1);
    wait_idle("t3");
    check("t3_bytes", log_word(base, 4), 64'hA377A088);
    check("t3_acks3", ack_cnt[3] - a3, 1);
    check("t3_acks0", ack_cnt[0] - a0, 1);

    // TX_IDLE held low while a data byte is offered
    @(posedge clk); #1;
    base = tx_n; a1 = ack_cnt[1];
    push(1, 8'h99, 1'b1);
    c = 0;
    while (!(busy_a && grant_a == 4'b0010 && tx_ready_a && tx_data_a == 8'h99) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("t4_data_phase", 64'(c < 100), 64'd1);
    hold_low = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (!tx_ready_a || tx_data_a != 8'h99 || req_ack_a != 4'b0 || tx_idle_a) bad++;
      @(negedge clk);
    end
    check("t4_stable", bad, 0);
    hold_low = 1'b0;
    #1;
    check("t4_ack_on_idle", {tx_idle_a, req_ack_a}, {1'b1, 4'b0010});
    wait_idle("t4");
    check("t4_acks", ack_cnt[1] - a1, 1);
    check("t4_bytes", log_word(base, 2), 64'hA199);

    // Asynchronous reset in the middle of requester 2's packet
    @(posedge clk); #1;
    a2 = ack_cnt[2];
    push(2, 8'hAA, 1'b0); push(2, 8'hBB, 1'b0); push(2, 8'hCC, 1'b1);
    wait_ack("t5", 2);
    @(posedge clk); #3;
    rst_n_a = 1'b0;
    #1;
    check("t5_rst_outs", {grant_a, req_ack_a, busy_a, tx_ready_a, tx_data_a}, 64'd0);
    for (int i = 0; i < 4; i++) wr_a[i] = rd_a[i];
    repeat (2) @(posedge clk);
    check("t5_acks_in_rst", ack_cnt[2] - a2, 1);
    @(negedge clk);
    rst_n_a = 1'b1;
    @(posedge clk); #1;
    base = tx_n;
    push(2, 8'h34, 1'b1); push(0, 8'h12, 1'b1);
    c = 0;
    while (grant_a == 4'b0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("t5_first_grant", grant_a, 64'h1);
    wait_idle("t5");
    check("t5_bytes", log_word(base, 4), 64'hA012A234);

    // Headerless single-requester build, back-to-back one-byte packets
    @(posedge clk); #1;
    push_b(8'h5A); push_b(8'h6B); push_b(8'h7C);
    ack_pat = '0; busy_pat = '0; bytes_b = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ack_pat[k]  = req_ack_b[0];
      busy_pat[k] = busy_b;
      if (req_ack_b[0]) bytes_b = {bytes_b[15:0], tx_data_b};
    end
    check("t6_ack_pattern", ack_pat, 8'h2A);
    check("t6_busy_pattern", busy_pat, 8'h2A);
    check("t6_bytes", bytes_b, 24'h5A6B7C);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_send transmitter between N_REQ byte-stream requesters, with round-robin arbitration at packet granularity. The granted requester keeps the UART until it sends a byte flagged LAST, or until it stalls longer than TIMEOUT cycles. An optional channel-ID header byte goes out before each packet. The block sits between the capture/debug sources and uart_send (TX_DATA→DATA, TX_DATA_READY→DATA_READY, TX_IDLE←IDLE).

Parameters:
N_REQ, 4, number of requesters (1..16)
SEND_HEADER, 1, 1 = emit header byte before each packet
HEADER_BASE, 8'hA0, header byte = HEADER_BASE + granted index, 8-bit wrap
TIMEOUT, 16'd50000, stall cycles before forced release; 0 = never release

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
REQ_DATA  in  8*N_REQ  byte from requester i at [8*i+7:8*i]
REQ_VALID  in  N_REQ  requester i has a byte pending
REQ_LAST  in  N_REQ  pending byte is the last of its packet
REQ_ACK  out  N_REQ  1-cycle pulse: byte of requester i accepted by UART
GRANT  out  N_REQ  one-hot, current owner of the UART
BUSY  out  1  a packet is in progress (state != ARB)
TX_DATA  out  8  to uart_send DATA
TX_DATA_READY  out  1  to uart_send DATA_READY
TX_IDLE  in  1  from uart_send IDLE

Behaviour:
- Transfer: a byte is taken in exactly the cycle where TX_DATA_READY && TX_IDLE. TX_IDLE may rise one cycle before the stop bit ends; this is legal.
- Reset (RST low, async):
  - State ARB, GRANT=0, REQ_ACK=0, TX_DATA_READY=0, TX_DATA=0, BUSY=0.
  - RR pointer=0; stall counter=0.
- Reset mid-packet: aborts silently. No ACK is issued. A byte that uart_send already sampled finishes in uart_send.
- ARB:
  - If any REQ_VALID, pick the first set bit at or after the pointer, cyclically.
  - Registered: GRANT=onehot(g), go to HDR if SEND_HEADER, else DATA.
  - Arbitration latency is 1 cycle. If nothing is valid, stay in ARB.
- HDR:
  - TX_DATA = HEADER_BASE + g (registered), TX_DATA_READY=1.
  - On transfer go to DATA. No REQ_ACK.
- DATA:
  - TX_DATA = REQ_DATA[g] and TX_DATA_READY = REQ_VALID[g], both combinational from the granted slice.
  - REQ_ACK[g] = transfer, same cycle. Requester advances on ACK.
  - On transfer with REQ_LAST[g]=1: GRANT=0, pointer=(g+1) mod N_REQ, go to ARB.
- Stall counter:
  - 16-bit. Increments in DATA when the transfer condition is false; clears on transfer and on entering DATA.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with no transfer: release exactly as for LAST, but without ACK.
  - The count covers both REQ_VALID low and TX_IDLE low, so TIMEOUT must exceed one byte time.
- Requester rules: REQ_DATA and REQ_LAST must stay stable while REQ_VALID=1 until ACK. VALID may drop between bytes.
- Non-granted requesters: never ACKed; their REQ_VALID is ignored outside ARB.
- Simultaneous events: LAST transfer and a new request in the same cycle → the new grant comes from ARB on the next cycle, using the updated pointer.
- Pointer: width max(1,clog2(N_REQ)); wraps at N_REQ-1→0. With N_REQ=1 the pointer is constant 0.

Decomposition:
- Shared package uart_pkg:
  - UART_BYTE_W=8.
  - State encodings ST_ARB/ST_HDR/ST_DATA.
  - Default HEADER_BASE.
  - START_BIT/STOP_BIT constants shared with uart_send.
- Sub-module rr_pick, purely combinational: inputs req[N_REQ] and pointer; outputs valid, index, onehot. Reusable by later arbiters.

Test Plan:
- Req0 sends bytes 11,22,33 (LAST on 33), SEND_HEADER=1, real uart_send on the bench → TXD serializes A0,11,22,33. Exactly three REQ_ACK[0] pulses; GRANT=0001 during the packet; BUSY low after.
- Req1 and req2 request simultaneously with pointer 0 → req1 served first (header A1), then req2 (header A2). Pointer ends at 3; no interleaving of bytes between packets.
- Req3 sends one non-LAST byte, then drops VALID, TIMEOUT=100 → release exactly 100 cycles after the stall starts. No extra ACK; next requester granted; pointer=0.
- TX_IDLE held low 20 cycles while VALID=1 → TX_DATA_READY=1 and TX_DATA stable throughout; single ACK in the first TX_IDLE=1 cycle.
- RST asserted mid-packet (asynchronously, between clock edges) → all outputs 0 immediately. After release, req0 is granted first again.
- SEND_HEADER=0, N_REQ=1, back-to-back single-byte LAST packets → no header bytes. One idle ARB cycle between packets; ACK per byte.
